fft_loader: RTL and testbench
=============================

Name: fft_loader

Overview:
- Upstream feeder for the in-place radix-2 FFT core.
- Accepts a stream of real signed samples through a valid/ready handshake and applies a Hann window from the existing hann_lut ROM.
- Writes each windowed sample as a complex word {re, 0} into the FFT working RAM at the bit-reversed address, so the core can run decimation-in-time in place.
- After N samples it pulses fft_start, then stalls input until the core reports fft_done.

Parameters:
- width, 16: complex word half-width; bits per re/im component.
- N_2, 5: log2 of FFT length N = 2**N_2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  upstream has a sample this cycle.
- sample  input  width-5  signed real sample; 5 bits of headroom are reserved for FFT bit growth.
- sample_ready  output  1  loader accepts a sample this cycle.
- we  output  1  RAM write enable.
- wadr  output  N_2  RAM write address, bit-reversed sample index.
- wd  output  2*width  RAM write data {re[width-1:0], im[width-1:0]}.
- fft_start  output  1  one-cycle pulse: frame loaded, start transform.
- fft_done  input  1  FFT core has finished the frame.
- busy  output  1  high from first accepted sample until fft_done is seen.

Behaviour:
- Reset (async, active-high):
  - state=LOAD, idx=0, pipeline valids cleared.
  - sample_ready=1, we=0, wadr=0, wd=0, fft_start=0, busy=0.
- Handshake:
  - Transfer occurs on a rising edge with sample_valid & sample_ready.
  - sample_ready is combinational from state only (=1 iff LOAD); no dependence on sample_valid.
- States:
  - LOAD: each transfer increments idx (N_2 bits).
    - Transfer with idx==N-1 → FLUSH, and sample_ready drops next cycle.
    - idx wraps to 0.
  - FLUSH: wait until both pipeline stages are empty (last write issued), then → START.
  - START: fft_start=1 for exactly one cycle → WAIT.
  - WAIT: sample_ready=0; on fft_done=1 → LOAD.
    - fft_done is ignored in all other states.
    - fft_done in the same cycle that START is exited is not sampled.
- Pipeline (2 stages):
  - Stage 1, on transfer: register sample and idx; hann_lut is addressed with idx, and its registered output aligns with stage 1.
  - Stage 2: product p = sample_s1 * coeff, signed (width-5)+width bits; coefficient is treated as non-negative Q1.(width-1).
    - windowed = p >>> (width-1), floor rounding, sign-extended to width.
    - Register windowed and bitrev(idx_s1).
  - Output: we=1 in the cycle after stage 2 holds valid data.
    - Latency: the write is visible 2 clocks after the transfer edge.
    - wadr = bit-reverse of idx; wd = {windowed, width'0}.
  - Back-to-back transfers give one write per cycle with no bubbles.
  - Gaps in sample_valid produce matching gaps in we.
- Boundary conditions:
  - we is never asserted outside LOAD/FLUSH.
  - fft_start never overlaps we.
  - busy: 1 from first transfer of a frame through the fft_done cycle; 0 in LOAD before the first transfer.
  - Reset mid-frame discards partial data; the next frame restarts at idx 0.
  - Coefficient 0 (idx 0) must write exactly 0.

Decomposition:
- Shared package fft_pkg:
  - Loader state enum {LOAD, FLUSH, START, WAIT}.
  - Function bitrev(N_2-bit).
  - Localparam N = 2**N_2.
- Reuse existing hann_lut #(width, N_2) as the sole sub-module.
- Multiply/shift and FSM stay inline.

Test Plan (width=16, N_2=5):
- Reset: assert reset mid-frame after 7 transfers → all outputs return to reset values immediately (async). After release, the next transfer writes wadr=0.
- Continuous stream of N samples, all sample=1000, valid held high:
  - 32 consecutive we cycles.
  - idx 1 → wadr 16; idx 3 → wadr 24.
  - idx 16 (coeff 32767) → wadr 1, wd={16'd999, 16'd0}.
  - idx 0 → wd=0.
  - One fft_start pulse follows the last write.
- Negative sample -1000 at idx 16 → wd re = -1000 (floor of -999.97), im = 0.
- Backpressure:
  - After 32 transfers, sample_ready=0 and valid held high → no further transfers or writes.
  - Pulse fft_done 10 cycles after start → sample_ready=1 next cycle; busy falls.
- Bubbly input (valid toggling 1,0,1,0) → writes spaced identically, each 2 clocks after its transfer; fft_start occurs once.
- fft_done pulse during LOAD → ignored; state, idx and sample_ready unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// fft_pkg : shared types and helpers for the FFT front end
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int DEFAULT_N_2 = 5;
  localparam int N           = 2 ** DEFAULT_N_2;
  localparam int MAX_N_2     = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } loader_state_t;

  // Reverses the low n bits of a; bits at and above n come back as zero.
  function automatic logic [MAX_N_2-1:0] bitrev(input logic [MAX_N_2-1:0] a, input int n);
    logic [MAX_N_2-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N_2; i++) begin
      if (i < n) r[n-1-i] = a[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_loader_if.sv
//------------------------------------------------------------------------------
// fft_loader_if : sample stream, RAM write port and FFT core handshake
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fft_loader_if #(
  parameter int width = 16,
  parameter int N_2   = 5
);

  logic                    sample_valid;
  logic signed [width-6:0] sample;
  logic                    sample_ready;
  logic                    we;
  logic [N_2-1:0]          wadr;
  logic [2*width-1:0]      wd;
  logic                    fft_start;
  logic                    fft_done;
  logic                    busy;

  modport master (
    input  sample_valid, sample, fft_done,
    output sample_ready, we, wadr, wd, fft_start, busy
  );

  modport slave (
    output sample_valid, sample, fft_done,
    input  sample_ready, we, wadr, wd, fft_start, busy
  );

endinterface

`default_nettype wire

// File: rtl/hann_lut.sv
//------------------------------------------------------------------------------
// hann_lut : registered Hann window ROM, unsigned Q1.(width-1) coefficients
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hann_lut #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  wire logic             clk,
  input  wire logic [N_2-1:0]   adr,
  output logic      [width-1:0] coeff
);

  logic [4:0]       t;
  logic [4:0]       h;
  logic [15:0]      q15;
  logic [width-1:0] coeff_d;
  logic [width-1:0] coeff_q;

  // The base table is a 32-point window; other lengths are resampled onto it.
  generate
    if (N_2 >= 5) begin : g_adr_down
      assign t = adr[N_2-1 -: 5];
    end else begin : g_adr_up
      assign t = {adr, {(5-N_2){1'b0}}};
    end
  endgenerate

  // Hann window is symmetric about the midpoint, so only half is stored.
  assign h = (t[4] && (t[3:0] != 4'd0)) ? 5'(6'd32 - {1'b0, t}) : t;

  always_comb begin
    q15 = 16'd0;
    case (h)
      5'd0:  q15 = 16'd0;
      5'd1:  q15 = 16'd315;
      5'd2:  q15 = 16'd1247;
      5'd3:  q15 = 16'd2761;
      5'd4:  q15 = 16'd4799;
      5'd5:  q15 = 16'd7281;
      5'd6:  q15 = 16'd10114;
      5'd7:  q15 = 16'd13187;
      5'd8:  q15 = 16'd16384;
      5'd9:  q15 = 16'd19580;
      5'd10: q15 = 16'd22653;
      5'd11: q15 = 16'd25486;
      5'd12: q15 = 16'd27968;
      5'd13: q15 = 16'd30006;
      5'd14: q15 = 16'd31520;
      5'd15: q15 = 16'd32452;
      5'd16: q15 = 16'd32767;
      default: q15 = 16'd0;
    endcase
  end

  generate
    if (width == 16) begin : g_scale_eq
      assign coeff_d = q15;
    end else if (width > 16) begin : g_scale_up
      assign coeff_d = {q15, {(width-16){1'b0}}};
    end else begin : g_scale_down
      assign coeff_d = q15[15 -: width];
    end
  endgenerate

  always_ff @(posedge clk) begin
    coeff_q <= coeff_d;
  end

  assign coeff = coeff_q;

endmodule

`default_nettype wire

// File: rtl/fft_loader.sv
//------------------------------------------------------------------------------
// fft_loader : windows a real sample stream and writes it bit-reversed into
//              the FFT working RAM, then hands the frame to the FFT core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_loader
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = DEFAULT_N_2
) (
  input  wire logic    clk,
  input  wire logic    reset,
  fft_loader_if.master bus
);

  localparam int SW = width - 5;
  localparam int PW = 2 * width - 4;

  loader_state_t state_q, state_d;

  logic [N_2-1:0]          idx_q, idx_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [SW-1:0]    s1_sample_q, s1_sample_d;
  logic [N_2-1:0]          s1_idx_q, s1_idx_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [width-1:0] s2_re_q, s2_re_d;
  logic [N_2-1:0]          s2_adr_q, s2_adr_d;
  logic                    we_q, we_d;
  logic [N_2-1:0]          wadr_q, wadr_d;
  logic [2*width-1:0]      wd_q, wd_d;

  logic                    transfer;
  logic [width-1:0]        coeff;
  logic signed [PW-1:0]    prod;
  logic signed [width-1:0] windowed;

  hann_lut #(
    .width (width),
    .N_2   (N_2)
  ) u_hann_lut (
    .clk   (clk),
    .adr   (idx_q),
    .coeff (coeff)
  );

  assign transfer = bus.sample_valid && (state_q == LOAD);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (transfer && (&idx_q)) state_d = FLUSH;
      FLUSH:   if (!s1_valid_q && !s2_valid_q) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (bus.fft_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.sample_ready = (state_q == LOAD);
    bus.fft_start    = (state_q == START);
    bus.busy         = (state_q != LOAD) || (idx_q != '0);
  end

  // ---------------- datapath ----------------
  // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod     = PW'(s1_sample_q) * PW'($signed({1'b0, coeff}));
  assign windowed = width'(prod >>> (width - 1));

  always_comb begin
    idx_d       = transfer ? idx_q + 1'b1 : idx_q;
    s1_valid_d  = transfer;
    s1_sample_d = transfer ? bus.sample : s1_sample_q;
    s1_idx_d    = transfer ? idx_q : s1_idx_q;
    s2_valid_d  = s1_valid_q;
    s2_re_d     = s1_valid_q ? windowed : s2_re_q;
    s2_adr_d    = s1_valid_q ? N_2'(bitrev(MAX_N_2'(s1_idx_q), N_2)) : s2_adr_q;
    we_d        = s2_valid_q;
    wadr_d      = s2_valid_q ? s2_adr_q : wadr_q;
    wd_d        = s2_valid_q ? {s2_re_q, {width{1'b0}}} : wd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_re_q     <= '0;
      s2_adr_q    <= '0;
      we_q        <= 1'b0;
      wadr_q      <= '0;
      wd_q        <= '0;
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_idx_q    <= s1_idx_d;
      s2_valid_q  <= s2_valid_d;
      s2_re_q     <= s2_re_d;
      s2_adr_q    <= s2_adr_d;
      we_q        <= we_d;
      wadr_q      <= wadr_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.we   = we_q;
  assign bus.wadr = wadr_q;
  assign bus.wd   = wd_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_loader.sv
//------------------------------------------------------------------------------
// tb_fft_loader : scoreboard and vector-table bench for fft_loader
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_loader;
  import fft_pkg::*;

  logic clk;
  logic reset;

  fft_loader_if #(.width(16), .N_2(5)) bus ();

  fft_loader #(.width(16), .N_2(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          adr;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    int idx;
    int smp;
    int exp_wadr;
    int exp_re;
  } vec_t;

  // Hann window, round(32767 * sin^2(pi*i/32)) for i = 0..16
  int half_tab [0:16] = '{0, 315, 1247, 2761, 4799, 7281, 10114, 13187, 16384,
                          19580, 22653, 25486, 27968, 30006, 31520, 32452, 32767};
  int coeff_tab [0:N-1];

  exp_t        exp_q [$];
  logic [31:0] ram [0:N-1];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tb_idx = 0;
  int xfers = 0;
  int starts = 0;
  int last_start_cyc = 0;
  int run = 0;
  int max_run = 0;
  bit abort = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int tb_rev(input int i);
    int r = 0;
    for (int b = 0; b < 5; b++) r |= ((i >> b) & 1) << (4 - b);
    return r;
  endfunction

  function automatic logic [15:0] model_re(input int s, input int c);
    longint p = longint'(s) * longint'(c);
    return 16'(p >>> 15);
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: push on each accepted sample, pop on each RAM write.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      tb_idx = 0;
      run    = 0;
    end else begin
      if (bus.we) begin
        run++;
        if (run > max_run) max_run = run;
        check("we_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("we_latency", cyc, e.cyc);
          check("wadr", bus.wadr, e.adr);
          check("wd", bus.wd, e.wd);
        end
        ram[bus.wadr] = bus.wd;
      end else begin
        run = 0;
      end
      if (bus.fft_start) begin
        starts++;
        last_start_cyc = cyc;
        check("start_no_we", bus.we, 0);
        check("start_after_writes", exp_q.size(), 0);
      end
      if (bus.sample_valid && bus.sample_ready) begin
        e.cyc = cyc + 3;
        e.adr = tb_rev(tb_idx);
        e.wd  = {model_re(int'(bus.sample), coeff_tab[tb_idx]), 16'h0000};
        exp_q.push_back(e);
        tb_idx = (tb_idx + 1) % N;
        xfers++;
      end
    end
  end

  task automatic send(input logic signed [10:0] s);
    int t;
    if (abort) return;
    bus.sample_valid = 1'b1;
    bus.sample       = s;
    t = 0;
    @(negedge clk);
    while (!bus.sample_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.sample_ready) begin
      check("ready_timeout", bus.sample_ready, 1);
      abort = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int first, input int n, input bit gap,
                            input int probe_idx, input int probe_smp);
    for (int i = first; i < first + n; i++) begin
      send((i == probe_idx) ? 11'(probe_smp) : 11'sd1000);
      if (i == 0) check("busy_after_first", bus.busy, 1);
      if (gap) begin
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic finish_frame(input int starts_before);
    int t = 0;
    while (starts == starts_before && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    while (cyc < last_start_cyc + 10) @(posedge clk);
    #1;
    check("one_start_per_frame", starts - starts_before, 1);
    bus.sample_valid = 1'b0;
    bus.fft_done     = 1'b1;
    #1;
    check("ready_in_wait", bus.sample_ready, 0);
    check("busy_in_done_cycle", bus.busy, 1);
    @(posedge clk);
    #1;
    bus.fft_done = 1'b0;
    check("ready_after_done", bus.sample_ready, 1);
    check("busy_after_done", bus.busy, 0);
  endtask

  vec_t vecs [13];

  initial begin
    int sb;
    int xb;
    for (int i = 0; i < N; i++) coeff_tab[i] = (i <= 16) ? half_tab[i] : half_tab[N - i];
    for (int i = 0; i < N; i++) ram[i] = '0;

    vecs = '{
      '{0,    1000,  0,     0},
      '{1,    1000,  16,    9},
      '{3,    1000,  24,    84},
      '{16,   1000,  1,     999},
      '{16,  -1000,  1,    -1000},
      '{8,    1000,  2,     500},
      '{8,   -1000,  2,    -500},
      '{31,   1000,  31,    9},
      '{31,  -1,     31,   -1},
      '{24,   1023,  3,     511},
      '{16,  -1024,  1,    -1024},
      '{5,    1,     20,    0},
      '{12,  -7,     6,    -6}
    };

    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.fft_done     = 1'b0;
    reset            = 1'b0;
    #2 reset = 1'b1;

    @(negedge clk);
    check("rst_ready", bus.sample_ready, 1);
    check("rst_we", bus.we, 0);
    check("rst_wadr", bus.wadr, 0);
    check("rst_wd", bus.wd, 0);
    check("rst_start", bus.fft_start, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_ready", bus.sample_ready, 1);
    @(posedge clk);
    #1;

    // Continuous frame of 1000s, then backpressure with valid held high.
    sb = starts;
    max_run = 0;
    send_frame(0, N, 1'b0, -1, 0);
    bus.sample_valid = 1'b1;
    bus.sample       = 11'sd77;
    xb = xfers;
    repeat (10) @(negedge clk);
    check("bp_ready", bus.sample_ready, 0);
    check("bp_no_xfer", xfers, xb);
    check("bp_busy", bus.busy, 1);
    finish_frame(sb);
    check("run_32", max_run, 32);
    check("idx1_wadr16", ram[16], {16'd9, 16'd0});
    check("idx3_wadr24", ram[24], {16'd84, 16'd0});
    check("idx16_wadr1", ram[1], {16'd999, 16'd0});
    check("idx0_zero", ram[0], 0);

    // Vector table: one probed sample per frame.
    foreach (vecs[k]) begin
      logic [31:0] ew;
      sb = starts;
      send_frame(0, N, 1'b0, vecs[k].idx, vecs[k].smp);
      finish_frame(sb);
      ew = {16'(vecs[k].exp_re), 16'h0000};
      check($sformatf("vec%0d_wd", k), ram[vecs[k].exp_wadr], ew);
    end

    // Bubbly input: valid alternates 1,0.
    sb = starts;
    max_run = 0;
    send_frame(0, N, 1'b1, -1, 0);
    finish_frame(sb);
    check("bubbly_run", max_run, 1);

    // fft_done during LOAD is ignored.
    sb = starts;
    send_frame(0, 3, 1'b0, -1, 0);
    bus.fft_done = 1'b1;
    @(posedge clk);
    #1 bus.fft_done = 1'b0;
    check("done_in_load_ready", bus.sample_ready, 1);
    check("done_in_load_busy", bus.busy, 1);
    check("done_in_load_start", starts - sb, 0);
    send_frame(3, N - 3, 1'b0, -1, 0);
    finish_frame(sb);

    // Asynchronous reset mid-frame, then a fresh frame from idx 0.
    send_frame(0, 7, 1'b0, -1, 0);
    reset = 1'b1;
    #1;
    check("midrst_we", bus.we, 0);
    check("midrst_wadr", bus.wadr, 0);
    check("midrst_wd", bus.wd, 0);
    check("midrst_ready", bus.sample_ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_start", bus.fft_start, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    sb = starts;
    send_frame(0, N, 1'b0, 0, 500);
    finish_frame(sb);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
